// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the MEM-stage data memory.
//   size_e   : access size encoding carried on req_size
//   state_e  : controller FSM states
//   lane_be / lane_replicate / lane_extract : byte-lane enable, store data
//   replication and load extraction for little-endian sub-word accesses
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return 4'b0011 << offset;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-justified store data copied into every lane so that the byte
    // enables alone select what lands in the word.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic sext,
                                                 input logic [1:0] offset, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {offset, 3'b000});
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{sext & b[7]}}, b};
            SZ_HALF: return {{16{sext & h[15]}}, h};
            SZ_WORD: return word;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering between the request and the
// 32-bit memory word.
//   size, offset, wdata   -> byte_en, wword  (store path)
//   size, sext, offset, raw -> ldata          (load path)
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    always_comb begin
        byte_en = lane_be(size, offset);
        wword   = lane_replicate(size, wdata);
        ldata   = lane_extract(size, sext, offset, raw);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: clocked, single-outstanding data memory for the MEM stage.
// Parameters: DEPTH (32-bit words, power of two >= 4), LAT (1..8 cycles).
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid / req_ready      request handshake (accept on valid & ready)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata, rsp_err         extended load data / access rejected
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [2:0]  CNT_INIT = 3'(LAT - 1);

    state_e      state, state_nxt;
    logic [2:0]  cnt;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        fire;
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] raw;
    logic [3:0]  byte_en;
    logic [31:0] wword;
    logic [31:0] ldata;

    logic [3:0][7:0] mem [DEPTH];

    assign accept = req_valid & req_ready;
    assign fire   = (state == BUSY) && (cnt == '0);
    assign idx    = lat_addr[AW+1:2];
    assign raw    = mem[idx];

    // Any address bit above the array's byte range makes the access illegal.
    assign err = (lat_size == SZ_RSVD)
              || ((lat_size == SZ_HALF) && lat_addr[0])
              || ((lat_size == SZ_WORD) && (lat_addr[1:0] != 2'b00))
              || ((lat_addr >> (AW + 2)) != '0);

    dmem_lane_align u_align (
        .size    (lat_size),
        .sext    (lat_signed),
        .offset  (lat_addr[1:0]),
        .wdata   (lat_wdata),
        .raw     (raw),
        .byte_en (byte_en),
        .wword   (wword),
        .ldata   (ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (accept) begin
            cnt        <= CNT_INIT;
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= fire;
            rsp_err   <= fire && err;
            rsp_rdata <= (fire && !err && !lat_write) ? ldata : '0;
        end
    end

    // Array is not reset; reset forces IDLE asynchronously, so fire is
    // already low on any edge while rst is held.
    always_ff @(posedge clk) begin
        if (fire && lat_write && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][i] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one instance with LAT=1 and one with LAT=4 share a clock,
// reset and request fields; each has its own req_valid and outputs.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        valid1 = 1'b0, ready1, rvalid1, rerr1;
    logic [31:0] rdata1;
    logic        valid4 = 1'b0, ready4, rvalid4, rerr4;
    logic [31:0] rdata4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(512), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rvalid1), .rsp_rdata(rdata1), .rsp_err(rerr1)
    );

    data_mem_ctrl #(.DEPTH(512), .LAT(4)) u4 (
        .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(ready4),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rvalid4), .rsp_rdata(rdata4), .rsp_err(rerr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge. Returns at the negedge where the response is seen.
    // k counts negedges after the acceptance edge (LAT+1 expected); lows
    // counts those negedges with req_ready low; waits counts cycles spent
    // waiting for req_ready before acceptance.
    task automatic xact(input bit sel4, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int k, output int lows, output int waits);
        bit got;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (sel4) valid4 = 1'b1; else valid1 = 1'b1;
        waits = 0;
        while (!(sel4 ? ready4 : ready1) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) chk("ready_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid4 = 1'b0;
        // Scramble the request fields: they must not matter after acceptance.
        req_write  = ~wr;
        req_size   = ~sz;
        req_signed = ~sg;
        req_addr   = ~a;
        req_wdata  = ~wd;
        k = 0;
        lows = 0;
        got = 1'b0;
        rd = 'x;
        er = 1'bx;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (!(sel4 ? ready4 : ready1)) lows++;
            if (sel4 ? rvalid4 : rvalid1) begin
                got = 1'b1;
                rd  = sel4 ? rdata4 : rdata1;
                er  = sel4 ? rerr4 : rerr1;
            end
        end
    endtask

    task automatic op(input string tag, input bit sel4, input bit wr, input logic [1:0] sz,
                      input bit sg, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd;
        logic er;
        int k, lows, waits;
        xact(sel4, wr, sz, sg, a, wd, rd, er, k, lows, waits);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        chk({tag, "_lat"}, 32'(k), sel4 ? 32'd5 : 32'd2);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int k, lows, waits;
        bit seen;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready1", {31'b0, ready1}, 32'd1);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_err1", {31'b0, rerr1}, 32'd0);
        chk("rst_ready4", {31'b0, ready4}, 32'd1);
        chk("rst_rvalid4", {31'b0, rvalid4}, 32'd0);
        @(negedge clk);

        // LAT=1 word store/load
        op("sw10", 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        op("lw10", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        // Sub-word stores and extension
        op("sw20", 0, 1, 2'd2, 0, 32'h20, 32'h00000000, 32'h0, 0);
        op("sb21", 0, 1, 2'd0, 0, 32'h21, 32'hAAAAAA80, 32'h0, 0);
        op("sh22", 0, 1, 2'd1, 0, 32'h22, 32'h5555F00D, 32'h0, 0);
        op("lw20", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("lw20s", 0, 0, 2'd2, 1, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("lb21", 0, 0, 2'd0, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0);
        op("lbu21", 0, 0, 2'd0, 0, 32'h21, 32'h0, 32'h00000080, 0);
        op("lb23", 0, 0, 2'd0, 1, 32'h23, 32'h0, 32'hFFFFFFF0, 0);
        op("lh22", 0, 0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFFF00D, 0);
        op("lhu22", 0, 0, 2'd1, 0, 32'h22, 32'h0, 32'h0000F00D, 0);
        op("lhu20", 0, 0, 2'd1, 0, 32'h20, 32'h0, 32'h00008000, 0);

        // Top word and word 0 (alias target of 0x800)
        op("sw7fc", 0, 1, 2'd2, 0, 32'h7FC, 32'h0BADF00D, 32'h0, 0);
        op("sw0", 0, 1, 2'd2, 0, 32'h0, 32'h11111111, 32'h0, 0);
        op("lw7fc", 0, 0, 2'd2, 0, 32'h7FC, 32'h0, 32'h0BADF00D, 0);

        // Error cases; 0x20 must stay intact after each
        op("e_lw22", 0, 0, 2'd2, 0, 32'h22, 32'h0, 32'h0, 1);
        op("e_lw22_chk", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("e_sh21", 0, 1, 2'd1, 0, 32'h21, 32'h0000BEEF, 32'h0, 1);
        op("e_sh21_chk", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("e_sz3", 0, 1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1);
        op("e_sz3_chk", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("e_sw800", 0, 1, 2'd2, 0, 32'h800, 32'hCAFEBABE, 32'h0, 1);
        op("e_lw800", 0, 0, 2'd2, 0, 32'h800, 32'h0, 32'h0, 1);
        op("e_sw820", 0, 1, 2'd2, 0, 32'h820, 32'hCAFEBABE, 32'h0, 1);
        op("e_range_chk20", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hF00D8000, 0);
        op("e_range_chk0", 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h11111111, 0);
        op("e_lb_sz3", 0, 0, 2'd3, 1, 32'h20, 32'h0, 32'h0, 1);

        // LAT=4 handshake and back-to-back ordering
        @(negedge clk);
        xact(1, 1, 2'd2, 0, 32'h30, 32'hA5A5A5A5, rd, er, k, lows, waits);
        chk("l4_sw_lat", 32'(k), 32'd5);
        chk("l4_sw_ready_lows", 32'(lows), 32'd4);
        chk("l4_sw_ready_at_rsp", {31'b0, ready4}, 32'd1);
        chk("l4_sw_err", {31'b0, er}, 32'd0);
        xact(1, 0, 2'd2, 0, 32'h30, 32'h0, rd, er, k, lows, waits);
        chk("l4_b2b_waits", 32'(waits), 32'd0);
        chk("l4_b2b_rdata", rd, 32'hA5A5A5A5);
        chk("l4_b2b_lat", 32'(k), 32'd5);
        chk("l4_b2b_lows", 32'(lows), 32'd4);
        @(negedge clk);
        chk("l4_pulse", {31'b0, rvalid4}, 32'd0);
        chk("l4_pulse_rdata", rdata4, 32'd0);
        op("l4_sb31", 1, 1, 2'd0, 0, 32'h31, 32'h0000003C, 32'h0, 0);
        op("l4_lw30", 1, 0, 2'd2, 0, 32'h30, 32'h0, 32'hA5A53CA5, 0);
        op("l4_e_lw31", 1, 0, 2'd2, 0, 32'h31, 32'h0, 32'h0, 1);

        // Reset mid-operation
        op("l4_sw40", 1, 1, 2'd2, 0, 32'h40, 32'h00000000, 32'h0, 0);
        req_write  = 1'b1;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_wdata  = 32'h12345678;
        valid4     = 1'b1;
        chk("mid_ready_before", {31'b0, ready4}, 32'd1);
        @(posedge clk);
        #1 valid4 = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'b0, ready4}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_ready_now", {31'b0, ready4}, 32'd1);
        chk("mid_rvalid_now", {31'b0, rvalid4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid4) seen = 1'b1;
        end
        chk("mid_no_rsp", {31'b0, seen}, 32'd0);
        op("mid_lw40", 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h00000000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
